// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: a single-outstanding fetch FSM feeding an in-order
// {instruction, PC} FIFO, flushed and refetched on a branch redirect.
module inst_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imem_req,
    output logic [31:0]            imem_addr,
    input  logic                   imem_ack,
    input  logic                   imem_rvalid,
    input  logic [31:0]            imem_rdata,
    output logic                   inst_valid,
    input  logic                   inst_ready,
    output logic [31:0]            inst,
    output logic [31:0]            inst_pc,
    input  logic                   redirect,
    input  logic [31:0]            redirect_pc,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned PW   = $clog2(DEPTH);
    localparam int unsigned CW   = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   word_q [DEPTH];
    logic [31:0]   pc_q   [DEPTH];
    logic          push;
    logic          pop;

    // With one request in flight, count < DEPTH at request time already
    // guarantees the slot for its response.
    assign imem_req   = !rst && (state_q == S_IDLE) && (count_q < FULL) && !redirect;
    assign imem_addr  = fetch_pc_q;
    assign inst_valid = (count_q != '0);
    assign inst       = word_q[rd_ptr_q];
    assign inst_pc    = pc_q[rd_ptr_q];
    assign count      = count_q;
    assign pop        = inst_valid && inst_ready && !redirect;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        push       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (imem_req && imem_ack) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    state_d = S_IDLE;
                    if (!redirect) begin
                        push       = 1'b1;
                        fetch_pc_d = fetch_pc_q + 32'd4;
                    end
                end else if (redirect) begin
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                // A redirect arriving with the stale response still retires it.
                if (imem_rvalid) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (redirect) fetch_pc_d = redirect_pc;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (redirect) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            word_q[wr_ptr_q] <= imem_rdata;
            pc_q[wr_ptr_q]   <= fetch_pc_q;
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: a behavioural instruction memory
// plus an expected-{pc,word} scoreboard checked on every decoder pop.
module tb_inst_fetch_queue;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [2:0]  count;

    int unsigned checks = 0;
    int unsigned errors = 0;
    exp_t        sb[$];

    // memory model controls
    int unsigned mem_lat    = 1;
    bit          mem_manual = 1'b0;
    logic        man_ack    = 1'b0;
    logic        man_rvalid = 1'b0;
    logic [31:0] man_rdata  = 32'h0;
    int unsigned acc_cnt    = 0;

    inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .inst_pc(inst_pc),
        .redirect(redirect), .redirect_pc(redirect_pc), .count(count)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mword(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic expect_seq(input logic [31:0] start, input int unsigned n);
        logic [31:0] a;
        a = start;
        for (int unsigned i = 0; i < n; i++) begin
            sb.push_back('{pc: a, word: mword(a)});
            a = a + 32'd4;
        end
    endtask

    // Memory: accepts at the edge following a request, answers mem_lat cycles later.
    task automatic responder_loop();
        bit          pend = 1'b0;
        int unsigned pend_cnt = 0;
        logic [31:0] pend_addr = 32'h0;
        imem_ack    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            #1;
            if (rst || mem_manual) pend = 1'b0;
            if (mem_manual) begin
                imem_ack    = man_ack;
                imem_rvalid = man_rvalid;
                imem_rdata  = man_rdata;
            end else begin
                imem_ack    = 1'b1;
                imem_rvalid = 1'b0;
                if (pend) begin
                    if (pend_cnt > 1) pend_cnt--;
                    else begin
                        imem_rvalid = 1'b1;
                        imem_rdata  = mword(pend_addr);
                        pend        = 1'b0;
                    end
                end
                if (imem_req && imem_ack) begin
                    pend      = 1'b1;
                    pend_cnt  = mem_lat;
                    pend_addr = imem_addr;
                    acc_cnt++;
                end
            end
        end
    endtask

    task automatic monitor_loop();
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && inst_valid && inst_ready && !redirect) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pop: got inst_pc %h, required no pop", inst_pc);
                end else begin
                    e = sb.pop_front();
                    checks++;
                    if (inst_pc !== e.pc) begin
                        errors++;
                        $display("FAIL pop_pc: got %h, required %h", inst_pc, e.pc);
                    end
                    checks++;
                    if (inst !== e.word) begin
                        errors++;
                        $display("FAIL pop_inst: got %h, required %h (pc %h)", inst, e.word, e.pc);
                    end
                end
            end
        end
    endtask

    // Returns at the negedge on which reset is released.
    task automatic apply_reset();
        @(negedge clk);
        rst        = 1'b1;
        inst_ready = 1'b0;
        redirect   = 1'b0;
        mem_manual = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drain(input int unsigned budget);
        int unsigned n;
        n = 0;
        @(negedge clk);
        inst_ready = 1'b1;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        inst_ready = 1'b0;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d entries left, required 0", sb.size());
        end
    endtask

    task automatic wait_accept(input int unsigned budget);
        int unsigned base;
        int unsigned n;
        base = acc_cnt;
        n = 0;
        #2;
        while (acc_cnt == base && n < budget) begin
            @(negedge clk);
            #2;
            n++;
        end
        checks++;
        if (acc_cnt == base) begin
            errors++;
            $display("FAIL accept_timeout: got no request accepted, required one");
        end
    endtask

    task automatic wait_count2(input int unsigned budget);
        int unsigned n;
        n = 0;
        do begin
            @(negedge clk);
            #2;
            n++;
        end while (count !== 3'd2 && n < budget);
        checks++;
        if (count !== 3'd2) begin
            errors++;
            $display("FAIL count2_timeout: got count %0d, required 2", count);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        mem_manual = 1'b1;
        man_ack    = 1'b0;
        man_rvalid = 1'b0;
        rst        = 1'b1;
        #2;
        checks++; if (imem_req !== 1'b0)   begin errors++; $display("FAIL rst_req: got %b, required 0", imem_req); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b, required 0", inst_valid); end
        checks++; if (count !== 3'd0)      begin errors++; $display("FAIL rst_count: got %0d, required 0", count); end
        repeat (2) @(negedge clk);
        rst        = 1'b0;
        inst_ready = 1'b1;
        #2;
        checks++; if (imem_req !== 1'b1)      begin errors++; $display("FAIL first_req: got %b, required 1", imem_req); end
        checks++; if (imem_addr !== RESET_PC) begin errors++; $display("FAIL first_addr: got %h, required %h", imem_addr, RESET_PC); end
        repeat (2) @(negedge clk);
        #2;
        checks++; if (count !== 3'd0)      begin errors++; $display("FAIL empty_pop_count: got %0d, required 0", count); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL empty_pop_valid: got %b, required 0", inst_valid); end
    endtask

    task automatic test_stream();
        mem_lat = 1;
        apply_reset();
        expect_seq(RESET_PC, 4);
        inst_ready = 1'b1;
        @(negedge clk);
        #2;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL lat_early_valid: got %b, required 0", inst_valid); end
        checks++; if (imem_req !== 1'b0)   begin errors++; $display("FAIL lat_wait_req: got %b, required 0", imem_req); end
        @(negedge clk);
        #2;
        checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL lat_valid: got %b, required 1", inst_valid); end
        checks++; if (count !== 3'd1)      begin errors++; $display("FAIL lat_count: got %0d, required 1", count); end
        drain(60);
    endtask

    task automatic test_full();
        int unsigned base;
        mem_lat = 1;
        apply_reset();
        base = acc_cnt;
        expect_seq(RESET_PC, 4);
        repeat (14) @(negedge clk);
        #2;
        checks++; if (count !== 3'd4)      begin errors++; $display("FAIL full_count: got %0d, required 4", count); end
        checks++; if (imem_req !== 1'b0)   begin errors++; $display("FAIL full_req: got %b, required 0", imem_req); end
        checks++; if (acc_cnt - base != 4) begin errors++; $display("FAIL full_fetches: got %0d, required 4", acc_cnt - base); end
        checks++; if (inst_pc !== RESET_PC) begin errors++; $display("FAIL full_head: got %h, required %h", inst_pc, RESET_PC); end
        base = acc_cnt;
        @(negedge clk);
        inst_ready = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
        repeat (6) @(negedge clk);
        #2;
        checks++; if (acc_cnt - base != 1) begin errors++; $display("FAIL refill_reqs: got %0d, required 1", acc_cnt - base); end
        checks++; if (count !== 3'd4)      begin errors++; $display("FAIL refill_count: got %0d, required 4", count); end
        expect_seq(RESET_PC + 32'd16, 1);
        drain(60);
    endtask

    task automatic test_push_pop();
        mem_lat = 1;
        apply_reset();
        expect_seq(RESET_PC, 4);
        wait_count2(40);
        @(negedge clk);
        inst_ready = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
        #2;
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL pushpop_count: got %0d, required 2", count); end
        checks++; if (inst_pc !== RESET_PC + 32'd4) begin errors++; $display("FAIL pushpop_head: got %h, required %h", inst_pc, RESET_PC + 32'd4); end
        checks++; if (inst !== mword(RESET_PC + 32'd4)) begin errors++; $display("FAIL pushpop_inst: got %h, required %h", inst, mword(RESET_PC + 32'd4)); end
        drain(60);
    endtask

    task automatic test_redirect_wait();
        mem_lat = 3;
        apply_reset();
        wait_accept(20);
        @(negedge clk);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0100;
        @(negedge clk);
        redirect = 1'b0;
        #2;
        checks++; if (imem_req !== 1'b0)          begin errors++; $display("FAIL drop_req: got %b, required 0", imem_req); end
        checks++; if (imem_addr !== 32'h0000_0100) begin errors++; $display("FAIL drop_addr: got %h, required 00000100", imem_addr); end
        checks++; if (count !== 3'd0)             begin errors++; $display("FAIL drop_count: got %0d, required 0", count); end
        @(negedge clk);
        @(negedge clk);
        #2;
        checks++; if (count !== 3'd0)    begin errors++; $display("FAIL stale_count: got %0d, required 0", count); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL refetch_req: got %b, required 1", imem_req); end
        checks++; if (imem_addr !== 32'h0000_0100) begin errors++; $display("FAIL refetch_addr: got %h, required 00000100", imem_addr); end
        mem_lat = 1;
        expect_seq(32'h0000_0100, 2);
        drain(60);
    endtask

    task automatic test_redirect_rvalid();
        mem_lat = 1;
        apply_reset();
        wait_count2(40);
        @(negedge clk);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        inst_ready  = 1'b1;
        @(negedge clk);
        redirect   = 1'b0;
        inst_ready = 1'b0;
        #2;
        checks++; if (count !== 3'd0)      begin errors++; $display("FAIL rdrv_count: got %0d, required 0", count); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rdrv_valid: got %b, required 0", inst_valid); end
        checks++; if (imem_req !== 1'b1)   begin errors++; $display("FAIL rdrv_req: got %b, required 1", imem_req); end
        checks++; if (imem_addr !== 32'h0000_0200) begin errors++; $display("FAIL rdrv_addr: got %h, required 00000200", imem_addr); end
        expect_seq(32'h0000_0200, 2);
        drain(60);
    endtask

    task automatic test_wrap();
        mem_lat = 1;
        apply_reset();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0500;
        @(negedge clk);
        redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect = 1'b0;
        #2;
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL b2b_addr: got %h, required fffffffc", imem_addr); end
        checks++; if (imem_req !== 1'b1)           begin errors++; $display("FAIL b2b_req: got %b, required 1", imem_req); end
        expect_seq(32'hFFFF_FFFC, 3);
        drain(60);
    endtask

    task automatic test_reset_wait();
        mem_lat = 3;
        apply_reset();
        wait_accept(20);
        @(negedge clk);
        mem_manual = 1'b1;
        man_ack    = 1'b0;
        man_rvalid = 1'b0;
        rst        = 1'b1;
        #2;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL midrst_req: got %b, required 0", imem_req); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        man_rvalid = 1'b1;
        man_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        man_rvalid = 1'b0;
        #2;
        checks++; if (count !== 3'd0)      begin errors++; $display("FAIL late_count: got %0d, required 0", count); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL late_valid: got %b, required 0", inst_valid); end
        checks++; if (imem_addr !== RESET_PC) begin errors++; $display("FAIL late_addr: got %h, required %h", imem_addr, RESET_PC); end
        mem_lat    = 1;
        mem_manual = 1'b0;
        expect_seq(RESET_PC, 2);
        drain(60);
    endtask

    initial begin
        fork
            responder_loop();
            monitor_loop();
        join_none
        test_reset();
        test_stream();
        test_full();
        test_push_pop();
        test_redirect_wait();
        test_redirect_rvalid();
        test_wrap();
        test_reset_wait();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
